// File: rtl/add_share_sched.sv
// Round-robin front end sharing one two-stage pipelined adder between NUM_REQ requesters.
// S1 captures the granted operand pair; S2 holds the registered sum that drives the result port.
module add_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              IN_reqValid,
    output logic [NUM_REQ-1:0]              OUT_reqReady,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   IN_reqA,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   IN_reqB,
    output logic                            OUT_resValid,
    input  logic                            IN_resReady,
    output logic [WIDTH-1:0]                OUT_resSum,
    output logic                            OUT_resCarry,
    output logic [ID_W-1:0]                 OUT_resId,
    output logic                            OUT_busy
);

    // Handshake: a requester transfers on IN_reqValid[i] & OUT_reqReady[i]; a result
    // leaves on OUT_resValid & IN_resReady. Valid never depends on the matching ready.

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [ID_W-1:0]  id1_q, id1_d;

    logic             v2_q, v2_d;
    logic [WIDTH-1:0] sum2_q, sum2_d;
    logic             carry2_q, carry2_d;
    logic [ID_W-1:0]  id2_q, id2_d;

    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             s2_free, s1_free, s1_to_s2;
    logic             found, grant_vld;
    logic [ID_W-1:0]  grant_id, idx;
    logic [WIDTH:0]   sum_full;

    assign s2_free  = !v2_q || IN_resReady;
    assign s1_free  = !v1_q || s2_free;
    assign s1_to_s2 = v1_q && s2_free;
    assign sum_full = {1'b0, a1_q} + {1'b0, b1_q};

    // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && IN_reqValid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        grant_vld    = found && s1_free && !rst;
        OUT_reqReady = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
    end

    always_comb begin
        ptr_d    = ptr_q;
        v1_d     = v1_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        id1_d    = id1_q;
        v2_d     = v2_q;
        sum2_d   = sum2_q;
        carry2_d = carry2_q;
        id2_d    = id2_q;

        if (s1_to_s2) begin
            v2_d     = 1'b1;
            sum2_d   = sum_full[WIDTH-1:0];
            carry2_d = sum_full[WIDTH];
            id2_d    = id1_q;
        end else if (v2_q && IN_resReady) begin
            v2_d = 1'b0;
        end

        if (grant_vld) begin
            v1_d  = 1'b1;
            a1_d  = IN_reqA[grant_id];
            b1_d  = IN_reqB[grant_id];
            id1_d = grant_id;
            if (int'(grant_id) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id + ID_W'(1);
            end
        end else if (s1_to_s2) begin
            v1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            v1_q     <= 1'b0;
            a1_q     <= '0;
            b1_q     <= '0;
            id1_q    <= '0;
            v2_q     <= 1'b0;
            sum2_q   <= '0;
            carry2_q <= 1'b0;
            id2_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            v1_q     <= v1_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            id1_q    <= id1_d;
            v2_q     <= v2_d;
            sum2_q   <= sum2_d;
            carry2_q <= carry2_d;
            id2_q    <= id2_d;
        end
    end

    assign OUT_resValid = v2_q;
    assign OUT_resSum   = sum2_q;
    assign OUT_resCarry = carry2_q;
    assign OUT_resId    = id2_q;
    assign OUT_busy     = v1_q || v2_q;

endmodule

// File: tb/tb_add_share_sched.sv
// Directed bench for add_share_sched: arbitration order, latency, carry, backpressure,
// fairness and mid-flight reset, all against hand-computed values.
module tb_add_share_sched;
  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  req_a;
  logic [3:0][7:0]  req_b;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_sum;
  logic             res_carry;
  logic [1:0]       res_id;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_grant;
  logic [3:0] exp_rdy [5];
  logic [7:0] exp_sum [4];

  add_share_sched #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_reqValid  (req_valid),
    .OUT_reqReady (req_ready),
    .IN_reqA      (req_a),
    .IN_reqB      (req_b),
    .OUT_resValid (res_valid),
    .IN_resReady  (res_ready),
    .OUT_resSum   (res_sum),
    .OUT_resCarry (res_carry),
    .OUT_resId    (res_id),
    .OUT_busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    tick();
    req_valid = 4'b1111;
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_resvalid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", res_sum, 8'h00);
    check("rst_carry", res_carry, 1'b0);
    check("rst_id", res_id, 2'd0);
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    tick();

    // Single request from requester 2
    req_a[2] = 8'h0F; req_b[2] = 8'h01; req_valid = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    check("single_v1_resvalid", res_valid, 1'b0);
    check("single_v1_busy", busy, 1'b1);
    tick();
    check("single_resvalid", res_valid, 1'b1);
    check("single_sum", res_sum, 8'h10);
    check("single_carry", res_carry, 1'b0);
    check("single_id", res_id, 2'd2);
    tick();
    check("single_drained", res_valid, 1'b0);
    check("single_idle", busy, 1'b0);
    req_valid = 4'b1001;
    #1;
    check("single_ptr3", req_ready, 4'b1000);
    req_valid = 4'b0000;

    // All requesters valid straight out of reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = {8'h40, 8'h30, 8'h20, 8'h10};
    req_b = {8'h04, 8'h03, 8'h02, 8'h01};
    exp_sum = '{8'h11, 8'h22, 8'h33, 8'h44};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k >= 2) begin
        check($sformatf("rr_valid%0d", k), res_valid, 1'b1);
        check($sformatf("rr_id%0d", k), res_id, (k - 2) % 4);
        check($sformatf("rr_sum%0d", k), res_sum, exp_sum[(k - 2) % 4]);
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
    check("rr_drained", busy, 1'b0);

    // Backpressure: pointer sits at 2, consumer stalls for 5 cycles
    res_ready = 1'b0;
    req_valid = 4'b1111;
    exp_rdy = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    n_grant = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), req_ready, exp_rdy[k]);
      if (req_ready != 4'b0000) n_grant++;
      if (k >= 2) begin
        check($sformatf("bp_hold_valid%0d", k), res_valid, 1'b1);
        check($sformatf("bp_hold_sum%0d", k), res_sum, 8'h33);
        check($sformatf("bp_hold_id%0d", k), res_id, 2'd2);
      end
      tick();
    end
    check("bp_grants", n_grant, 2);
    req_valid = 4'b0000;
    res_ready = 1'b1;
    #1;
    check("bp_out0_id", res_id, 2'd2);
    check("bp_out0_sum", res_sum, 8'h33);
    tick();
    check("bp_out1_valid", res_valid, 1'b1);
    check("bp_out1_id", res_id, 2'd3);
    check("bp_out1_sum", res_sum, 8'h44);
    tick();
    check("bp_empty", res_valid, 1'b0);

    // Wrap and carry; pointer is back at 0
    req_a[0] = 8'hFF; req_b[0] = 8'h02; req_valid = 4'b0001;
    #1;
    check("wrap_ready0", req_ready, 4'b0001);
    tick();
    req_a[0] = 8'h00;
    req_a[1] = 8'h80; req_b[1] = 8'h80; req_valid = 4'b0010;
    #1;
    check("wrap_ready1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    check("wrap_sum0", res_sum, 8'h01);
    check("wrap_carry0", res_carry, 1'b1);
    check("wrap_id0", res_id, 2'd0);
    tick();
    check("wrap_sum1", res_sum, 8'h00);
    check("wrap_carry1", res_carry, 1'b1);
    check("wrap_id1", res_id, 2'd1);
    tick();
    check("wrap_empty", res_valid, 1'b0);

    // Fairness: requester 0 always valid, requester 3 asks once; pointer at 2
    req_valid = 4'b0001;
    #1;
    check("fair_g0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1001;
    #1;
    check("fair_g3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    #1;
    check("fair_g0_again", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("fair_drained", busy, 1'b0);

    // Reset with both stages occupied; pointer at 1
    req_a[1] = 8'h05; req_b[1] = 8'h06; req_valid = 4'b0110;
    tick();
    tick();
    req_valid = 4'b0000;
    check("mid_valid", res_valid, 1'b1);
    check("mid_id", res_id, 2'd1);
    check("mid_sum", res_sum, 8'h0B);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid0", res_valid, 1'b0);
    tick();
    check("post_rst_valid1", res_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    req_valid = 4'b1100;
    #1;
    check("post_rst_first", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    check("post_rst_res_id", res_id, 2'd2);
    check("post_rst_res_sum", res_sum, 8'h33);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Round-robin scheduler that shares one two-stage pipelined adder datapath between NUM_REQ requesters.
- Each requester presents an operand pair through a valid/ready handshake. The block grants at most one pair per cycle and tags it with the requester index.
- Each result is returned on a single valid/ready result port. Backpressure stalls the pipeline without losing data.
- Sits between several producer blocks and the one shared adder instance, replacing per-requester adders.

Parameters:
- NUM_REQ, 4, number of requesters (>= 2).
- WIDTH, 8, operand and sum width in bits (>= 1).
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- IN_reqValid  input  NUM_REQ  per-requester operand valid
- OUT_reqReady  output  NUM_REQ  per-requester grant; one-hot or zero
- IN_reqA  input  NUM_REQ x WIDTH  operand A, one slice per requester
- IN_reqB  input  NUM_REQ x WIDTH  operand B, one slice per requester
- OUT_resValid  output  1  result valid
- IN_resReady  input  1  result consumer ready
- OUT_resSum  output  WIDTH  (A+B) mod 2^WIDTH
- OUT_resCarry  output  1  carry-out of A+B
- OUT_resId  output  ID_W  index of the requester that issued the result
- OUT_busy  output  1  high when any pipeline stage holds valid data

Behaviour:
- Reset (async, active-high) clears:
  - stage-1 and stage-2 valid bits;
  - priority pointer to 0;
  - OUT_resValid, OUT_resSum, OUT_resCarry, OUT_resId, OUT_busy to 0.
- OUT_reqReady is combinational and is 0 while rst is high.
- Pipeline:
  - S1 register holds A, B, ID and v1.
  - S2 register holds sum, carry, ID and v2; S2 drives the result outputs directly, with OUT_resValid = v2.
- Advance rules, all evaluated in the same cycle:
  - s2_free = !v2 | IN_resReady.
  - s1_free = !v1 | s2_free.
  - S1 moves into S2 when v1 & s2_free.
  - S2 clears when v2 & IN_resReady and nothing moves in.
- Arbitration:
  - Requester i is granted when s1_free, IN_reqValid[i], and i is the first valid index found scanning from the pointer upward, modulo NUM_REQ.
  - OUT_reqReady[i] is high only for the granted index.
  - A transfer occurs on IN_reqValid[i] & OUT_reqReady[i].
  - On a transfer from i, the pointer becomes (i+1) mod NUM_REQ. Otherwise the pointer holds.
- Latency:
  - A transfer at edge t gives OUT_resValid high after edge t+1, i.e. two register stages.
  - Throughput is one result per cycle when IN_resReady is held high.
- Arithmetic:
  - Compute in S1 → S2 as a WIDTH+1-bit sum {carry, sum} = zero-extended A + zero-extended B.
  - Unsigned; no saturation.
- Backpressure: when v2 & !IN_resReady, S2 holds:
  - If v1, S1 also holds and all OUT_reqReady are 0.
  - If !v1, S1 may accept one more request. That gives at most 2 results in flight while stalled.
- While v2 is high, OUT_resSum, OUT_resCarry and OUT_resId stay stable until IN_resReady. When v2 is low these outputs hold their last values (don't-care).
- Simultaneous events:
  - A result leaving S2, S1 moving to S2 and a new grant into S1 may all happen in one cycle.
  - A requester may be re-granted only after all other pending requesters have been served once (fairness bound: NUM_REQ-1 intervening grants).
- Requester contract: IN_reqA and IN_reqB are sampled only on the transfer edge. The requester may drop or change valid without a grant; no penalty and no pointer change.
- Reset mid-operation discards in-flight data immediately. No partial result is emitted after rst deasserts.
- OUT_busy = v1 | v2.

Test Plan:
- Single request: WIDTH=8, requester 2 sends A=8'h0F, B=8'h01 with IN_resReady=1 → OUT_reqReady=4'b0100 that cycle; two cycles later OUT_resValid=1, sum=8'h10, carry=0, id=2; pointer becomes 3.
- All four requesters valid continuously from reset, IN_resReady=1 → grants in order 0,1,2,3,0,…; one result per cycle with ids 0,1,2,3 matching their operands.
- Wrap/carry: A=8'hFF, B=8'h02 → sum=8'h01, carry=1. A=8'h80, B=8'h80 → sum=8'h00, carry=1.
- Backpressure: IN_resReady=0 for 5 cycles with all requesters valid → exactly 2 grants occur, OUT_resValid holds the first result stable, OUT_reqReady=0 afterwards. On release, results drain in order with no loss or duplication.
- Fairness: requester 0 always valid; requester 3 asserts valid once → requester 3 is granted within 1 further grant to requester 0, not starved.
- Reset mid-flight: assert rst one cycle after a transfer → OUT_resValid=0 and OUT_busy=0 immediately. After release, no stale result appears and the first grant goes to the lowest valid index.
